// File: rtl/cv_weights_loader_pkg.sv
// Constants and FSM encoding shared by the convolution weights reader and loader.
// Row geometry is fixed; the two weight modes only reinterpret the same row bits.
package cv_weights_loader_pkg;

  localparam int ROW_WIDTH          = 512;
  localparam int ADR_WIDTH          = 11;
  localparam int M0_WEIGHT_BITS     = 8;
  localparam int M0_WEIGHTS_PER_ROW = ROW_WIDTH / M0_WEIGHT_BITS;
  localparam int M1_GROUP_WEIGHTS   = 128;
  localparam int M1_GROUPS_PER_ROW  = ROW_WIDTH / M1_GROUP_WEIGHTS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } cv_state_t;

endpackage

// File: rtl/cv_weights_loader_row_packer.sv
// Assembles narrow stream words into one weight row. The combinational row output
// already contains the word being presented, so a completing word needs no extra cycle.
module cv_row_packer #(
  parameter int IN_WIDTH  = 64,
  parameter int ROW_WIDTH = 512
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 accept,
  input  logic                 row_end,
  input  logic [IN_WIDTH-1:0]  word,
  output logic                 last_beat,
  output logic [ROW_WIDTH-1:0] row
);

  localparam int BEATS  = ROW_WIDTH / IN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BEAT_W-1:0]    beat_p0;
  logic [ROW_WIDTH-1:0] asm_p0;

  always_comb begin
    row = asm_p0;
    row[beat_p0*IN_WIDTH +: IN_WIDTH] = word;
    last_beat = (beat_p0 == BEAT_W'(BEATS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_p0 <= '0;
    end else if (clear || (accept && row_end)) begin
      beat_p0 <= '0;
    end else if (accept) begin
      beat_p0 <= beat_p0 + 1'b1;
    end
  end

  // Zero-fill on clear is what leaves unfilled beats of a short final row at zero.
  always_ff @(posedge clk) begin
    if (clear || (accept && row_end)) begin
      asm_p0 <= '0;
    end else if (accept) begin
      asm_p0[beat_p0*IN_WIDTH +: IN_WIDTH] <= word;
    end
  end

endmodule

// File: rtl/cv_weights_loader.sv
// Packs the DMA weight stream into 512-bit rows and writes them to consecutive
// weights-buffer addresses from a programmable base, flagging framing errors.
module cv_weights_loader
  import cv_weights_loader_pkg::*;
#(
  parameter int IN_WIDTH  = 64,
  parameter int ROW_WIDTH = cv_weights_loader_pkg::ROW_WIDTH,
  parameter int ADR_WIDTH = cv_weights_loader_pkg::ADR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic [ADR_WIDTH-1:0] load_base,
  input  logic [ADR_WIDTH:0]   load_rows,
  input  logic                 wt_in_valid,
  output logic                 wt_in_ready,
  input  logic [IN_WIDTH-1:0]  wt_in_data,
  input  logic                 wt_in_last,
  output logic                 wr_en,
  output logic [ADR_WIDTH-1:0] wr_adr,
  output logic [ROW_WIDTH-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  cv_state_t state, nxt;

  logic [ADR_WIDTH-1:0] base_p0;
  logic [ADR_WIDTH:0]   rows_p0;
  logic [ADR_WIDTH:0]   row_p0;
  logic [ROW_WIDTH-1:0] row_word;
  logic                 last_beat;
  logic                 start_ok, accept, final_row, row_end, finish, exact;

  logic                 wr_en_p1;
  logic [ADR_WIDTH-1:0] wr_adr_p1;
  logic [ROW_WIDTH-1:0] wr_data_p1;
  logic                 err_p1;

  cv_row_packer #(
    .IN_WIDTH  (IN_WIDTH),
    .ROW_WIDTH (ROW_WIDTH)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (accept),
    .row_end   (row_end),
    .word      (wt_in_data),
    .last_beat (last_beat),
    .row       (row_word)
  );

  assign start_ok  = (state == ST_IDLE) && load_start;
  assign accept    = (state == ST_FILL) && wt_in_valid;
  assign final_row = (row_p0 == rows_p0 - (ADR_WIDTH+1)'(1));
  assign row_end   = accept && (last_beat || wt_in_last);
  // A load ends on any last marker or on the final word of the final row;
  // only the two together are a clean completion.
  assign finish    = accept && (wt_in_last || (last_beat && final_row));
  assign exact     = last_beat && final_row && wt_in_last;

  always_comb begin
    nxt         = state;
    wt_in_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) nxt = (load_rows == '0) ? ST_DONE : ST_FILL;
      end
      ST_FILL: begin
        wt_in_ready = 1'b1;
        busy        = 1'b1;
        if (finish) nxt = ST_DONE;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      base_p0  <= '0;
      rows_p0  <= '0;
      row_p0   <= '0;
      wr_en_p1 <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      state    <= nxt;
      wr_en_p1 <= row_end;
      if (start_ok) begin
        base_p0 <= load_base;
        rows_p0 <= load_rows;
        row_p0  <= '0;
        err_p1  <= 1'b0;
      end else begin
        if (row_end) row_p0 <= row_p0 + 1'b1;
        if (finish && !exact) err_p1 <= 1'b1;
      end
    end
  end

  // Write stage: address wraps naturally at the buffer depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_adr_p1  <= '0;
      wr_data_p1 <= '0;
    end else if (row_end) begin
      wr_adr_p1  <= base_p0 + row_p0[ADR_WIDTH-1:0];
      wr_data_p1 <= row_word;
    end
  end

  assign wr_en   = wr_en_p1;
  assign wr_adr  = wr_adr_p1;
  assign wr_data = wr_data_p1;
  assign err     = err_p1;

endmodule

// File: tb/tb_cv_weights_loader.sv
// Directed bench for cv_weights_loader: table of load scenarios checked against a
// small row/address/timing model, plus reset-in-idle and reset-mid-load sequences.
module tb_cv_weights_loader;

  localparam int IN_W  = 64;
  localparam int ROW_W = 512;
  localparam int ADR_W = 11;

  typedef struct {
    logic [ADR_W-1:0] base;
    logic [ADR_W:0]   rows;
    int               nwords;
    int               last_idx;
    int               gap;
    int               exp_writes;
    logic             exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_start;
  logic [ADR_W-1:0] load_base;
  logic [ADR_W:0]   load_rows;
  logic             wt_in_valid;
  logic             wt_in_ready;
  logic [IN_W-1:0]  wt_in_data;
  logic             wt_in_last;
  logic             wr_en;
  logic [ADR_W-1:0] wr_adr;
  logic [ROW_W-1:0] wr_data;
  logic             busy, done, err;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [ADR_W-1:0] w_adr[8];
  logic [ROW_W-1:0] w_data[8];
  int               w_cyc[8];
  logic             w_done[8];
  int   nw = 0, n_done = 0, first_acc = -1, start_cyc = -1, done_cyc = -1;
  int   ready_drop = 0;
  logic busy_after = 1'b1, err_after_start = 1'b1, prev_done = 1'b0, in_fill = 1'b0;

  vec_t vecs[6];

  cv_weights_loader #(.IN_WIDTH(IN_W), .ROW_WIDTH(ROW_W), .ADR_WIDTH(ADR_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_rows(load_rows), .wt_in_valid(wt_in_valid), .wt_in_ready(wt_in_ready),
    .wt_in_data(wt_in_data), .wt_in_last(wt_in_last), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_data(wr_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_start && start_cyc < 0) start_cyc = cyc;
    if (start_cyc >= 0 && cyc == start_cyc + 1) err_after_start = err;
    if (wt_in_valid && wt_in_ready && first_acc < 0) first_acc = cyc;
    if (in_fill && !wt_in_ready) ready_drop++;
    if (wr_en) begin
      if (nw < 8) begin
        w_adr[nw] = wr_adr; w_data[nw] = wr_data; w_cyc[nw] = cyc; w_done[nw] = done;
      end
      nw++;
    end
    if (prev_done) busy_after = busy;
    if (done) begin n_done++; done_cyc = cyc; end
    prev_done = done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_bits(input string name, input logic [ROW_W-1:0] act,
                            input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] word_of(input int k);
    logic [7:0] b;
    b = 8'(k);
    return {8{b}};
  endfunction

  task automatic run_load(input vec_t v);
    nw = 0; n_done = 0; first_acc = -1; start_cyc = -1; done_cyc = -1;
    ready_drop = 0; busy_after = 1'b1; err_after_start = 1'b1;
    load_base = v.base; load_rows = v.rows; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    load_base  = '0;
    load_rows  = '0;
    in_fill    = (v.nwords > 0);
    for (int k = 0; k < v.nwords; k++) begin
      wt_in_valid = 1'b1;
      wt_in_data  = word_of(k);
      wt_in_last  = (k == v.last_idx);
      @(posedge clk); #1;
      if (v.gap != 0 && k != v.nwords - 1) begin
        wt_in_valid = 1'b0; wt_in_last = 1'b0; wt_in_data = '1;
        @(posedge clk); #1;
      end
    end
    in_fill = 1'b0;
    wt_in_valid = 1'b0; wt_in_last = 1'b0; wt_in_data = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare(input int i, input vec_t v);
    int ci, exp_done;
    logic [ADR_W-1:0] ea;
    logic [ROW_W-1:0] ed;
    check_int($sformatf("v%0d_nwrites", i), nw, v.exp_writes);
    exp_done = start_cyc + 1;
    for (int r = 0; r < v.exp_writes; r++) begin
      if (r < nw && r < 8) begin
        ci = (r*8 + 7 < v.nwords) ? r*8 + 7 : v.nwords - 1;
        ea = v.base + ADR_W'(r);
        ed = '0;
        for (int b = 0; b < 8; b++)
          if (r*8 + b < v.nwords) ed[b*IN_W +: IN_W] = word_of(r*8 + b);
        check_bits($sformatf("v%0d_adr%0d", i, r), ROW_W'(w_adr[r]), ROW_W'(ea));
        check_bits($sformatf("v%0d_data%0d", i, r), w_data[r], ed);
        check_int($sformatf("v%0d_wcyc%0d", i, r), w_cyc[r] - first_acc, ci*(v.gap + 1) + 1);
        exp_done = first_acc + ci*(v.gap + 1) + 1;
      end
    end
    check_int($sformatf("v%0d_ndone", i), n_done, 1);
    check_int($sformatf("v%0d_done_cyc", i), done_cyc, exp_done);
    check_int($sformatf("v%0d_busy_after_done", i), int'(busy_after), 0);
    check_int($sformatf("v%0d_idle", i), int'(busy), 0);
    check_int($sformatf("v%0d_err", i), int'(err), int'(v.exp_err));
    check_int($sformatf("v%0d_err_cleared", i), int'(err_after_start), 0);
    if (v.nwords > 0) check_int($sformatf("v%0d_ready_drop", i), ready_drop, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_int({tag, "_ctrl"}, int'({wt_in_ready, wr_en, busy, done, err}), 0);
    check_bits({tag, "_adr"}, ROW_W'(wr_adr), '0);
    check_bits({tag, "_data"}, wr_data, '0);
  endtask

  initial begin
    vecs[0] = '{11'h010, 12'd2, 16, 15, 0, 2, 1'b0};
    vecs[1] = '{11'h010, 12'd2, 16, 15, 1, 2, 1'b0};
    vecs[2] = '{11'h010, 12'd2, 11, 10, 0, 2, 1'b1};
    vecs[3] = '{11'h7FF, 12'd2, 16, 15, 0, 2, 1'b0};
    vecs[4] = '{11'h100, 12'd0,  0, -1, 0, 0, 1'b0};
    vecs[5] = '{11'h020, 12'd1,  8, -1, 0, 1, 1'b1};

    reset = 1'b1; load_start = 1'b0; load_base = '0; load_rows = '0;
    wt_in_valid = 1'b0; wt_in_data = '0; wt_in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i]);
      compare(i, vecs[i]);
    end

    // Reset in IDLE clears sticky err and the write-port registers.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero_outputs("idle_reset");

    // Reset after 5 words: no write, all outputs low, then a clean load.
    nw = 0;
    load_base = 11'h040; load_rows = 12'd1; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wt_in_valid = 1'b1; wt_in_data = word_of(k + 100); wt_in_last = 1'b0;
      @(posedge clk); #1;
    end
    wt_in_valid = 1'b0; wt_in_data = '0;
    check_int("midload_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midload_reset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_int("midload_no_write", nw, 0);
    check_zero_outputs("midload_after");

    run_load(vecs[0]);
    compare(6, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
